pixel_compositor: RTL and testbench
===================================

// Module: pixel_compositor
// PURPOSE
//   Downstream stage of background_controller and the sprite path. Merges the 4-bit background
//   and sprite palette indices into 12-bit RGB through two writable palettes, and delays the
//   raw VGA sync/active signals so they line up with the colour output. Palette writes are
//   buffered and committed only during blanking, so a frame never changes colour mid-scan.
// PARAMETERS
//   SRC_LATENCY   1     cycles from hcount/vcount issue to bg_pixel/sprite_pixel valid
//   TRANSPARENT   4'h0  sprite index treated as transparent
//   FRAME_W       8     width of the free-running frame counter
// PORTS
//   clk           in   1        pixel clock
//   reset         in   1        async, active-high
//   hsync_in      in   1        raw hsync, aligned with hcount issue (cycle 0)
//   vsync_in      in   1        raw vsync, cycle 0
//   vde_in        in   1        active-video flag, cycle 0
//   bg_pixel      in   4        background palette index, valid at cycle SRC_LATENCY
//   sprite_pixel  in   4        sprite palette index, valid at cycle SRC_LATENCY
//   sprite_valid  in   1        sprite covers this pixel, valid at cycle SRC_LATENCY
//   pal_we        in   1        palette write request
//   pal_sel       in   1        0 = background palette, 1 = sprite palette
//   pal_addr      in   4        palette entry
//   pal_data      in   12       {R[3:0],G[3:0],B[3:0]}
//   pal_ready     out  1        write buffer empty; a request is accepted when pal_we & pal_ready
//   red/green/blue out 4 each   colour output, at cycle SRC_LATENCY+2
//   hsync_out     out  1        hsync_in delayed SRC_LATENCY+2 cycles
//   vsync_out     out  1        vsync_in delayed SRC_LATENCY+2 cycles
//   vde_out       out  1        vde_in delayed SRC_LATENCY+2 cycles
//   frame_count   out  FRAME_W  counts vsync_in rising edges; wraps to 0
// BEHAVIOUR
//   Reset (async): all outputs 0, and the sync/vde delay lines are cleared to 0. pal_ready = 1.
//     Both palettes reset to 0x000. The write buffer is emptied, and any write that had not
//     yet committed is dropped.
//   Pipeline:
//     stage A (cycle SRC_LATENCY+1) registers idx = (sprite_valid && sprite_pixel != TRANSPARENT)
//       ? sprite_pixel : bg_pixel, plus a 1-bit source flag.
//     stage B (cycle SRC_LATENCY+2) registers the palette[src][idx] lookup into red/green/blue.
//       It forces 0 when the delayed vde is 0.
//     Total latency from hsync_in/vde_in to outputs: SRC_LATENCY+2 cycles. All three sync
//     outputs go through identical shift registers.
//   Palette write FSM, states EMPTY and PENDING:
//     EMPTY: pal_ready = 1. If pal_we, latch sel/addr/data.
//       vde_in == 0 in the same cycle: the write is committed at that clock edge and the
//         FSM stays EMPTY.
//       Otherwise: go to PENDING.
//     PENDING: pal_ready = 0 and pal_we is ignored. Commit on the first cycle with vde_in == 0,
//       then go to EMPTY. pal_ready is 1 again in the following cycle.
//     A committed entry affects lookups starting with the next stage-B register update.
//     On a same-cycle commit and lookup of the same entry, the lookup returns the old value.
//   frame_count: +1 on each 0->1 edge of vsync_in. Edge detect uses a registered copy of
//     vsync_in. The count wraps from 2^FRAME_W-1 to 0.
//   sprite_valid = 1 with sprite_pixel == TRANSPARENT selects the background index.
//   sprite_valid = 0 always selects the background index.
// TESTING
//   1. Reset. Expect all outputs 0 and pal_ready = 1. Pulse vde_in for 1 cycle: vde_out pulses
//      exactly 3 cycles later (SRC_LATENCY = 1).
//   2. Program bg[5] = 0xF00 and spr[5] = 0x0F0 during blanking. With vde = 1 and bg = 5:
//      sprite 5/valid gives 0x0F0; sprite 0/valid gives 0xF00; sprite 5 with valid = 0
//      gives 0xF00.
//   3. Write bg[2] = 0xABC while vde_in = 1. Expect pal_ready = 0 and output for idx 2 still 0x000.
//      Then drop vde_in: commit; pal_ready returns to 1 the next cycle; next active idx 2
//      outputs 0xABC.
//   4. While PENDING, issue a second pal_we with bg[2] = 0x123. It is ignored; only 0xABC
//      is committed.
//   5. With vde_out = 0 and a non-zero palette entry selected, RGB = 0.
//   6. Generate 256 vsync rising edges. frame_count wraps to 0. Assert reset mid-frame:
//      frame_count, RGB and syncs go to 0 immediately, and the pending write is discarded.

Source files
------------

// File: rtl/pixel_compositor_if.sv
// Palette write port: request fields from the master, buffer-empty flag back.
`timescale 1ns/1ps
interface pixel_compositor_if;
    logic        pal_we;
    logic        pal_sel;
    logic [3:0]  pal_addr;
    logic [11:0] pal_data;
    logic        pal_ready;

    modport master (
        output pal_we, pal_sel, pal_addr, pal_data,
        input  pal_ready
    );

    modport slave (
        input  pal_we, pal_sel, pal_addr, pal_data,
        output pal_ready
    );
endinterface

// File: rtl/pixel_compositor.sv
// Palette-index merge, blanking-deferred palette writes and sync alignment
// from the background/sprite sources to 12-bit RGB.
`timescale 1ns/1ps
module pixel_compositor #(
    parameter int         SRC_LATENCY = 1,
    parameter logic [3:0] TRANSPARENT = 4'h0,
    parameter int         FRAME_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               vde_in,
    input  logic [3:0]         bg_pixel,
    input  logic [3:0]         sprite_pixel,
    input  logic               sprite_valid,
    pixel_compositor_if.slave  pal,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               vde_out,
    output logic [FRAME_W-1:0] frame_count
);
    localparam int DLY = SRC_LATENCY + 2;

    typedef enum logic {EMPTY, PENDING} state_t;

    state_t      state, state_nx;
    logic [DLY-1:0] hs_d, vs_d, de_d;
    logic [3:0]  idx_a;
    logic        src_a;
    logic [11:0] bg_pal  [16];
    logic [11:0] spr_pal [16];
    logic [11:0] lookup;
    logic        buf_sel;
    logic [3:0]  buf_addr;
    logic [11:0] buf_data;
    logic        commit;
    logic        w_sel;
    logic [3:0]  w_addr;
    logic [11:0] w_data;
    logic        vs_q;
    logic        use_spr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_d <= '0;
            vs_d <= '0;
            de_d <= '0;
        end else begin
            hs_d <= {hs_d[DLY-2:0], hsync_in};
            vs_d <= {vs_d[DLY-2:0], vsync_in};
            de_d <= {de_d[DLY-2:0], vde_in};
        end
    end

    assign hsync_out = hs_d[DLY-1];
    assign vsync_out = vs_d[DLY-1];
    assign vde_out   = de_d[DLY-1];

    assign use_spr = sprite_valid && (sprite_pixel != TRANSPARENT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_a <= 4'h0;
            src_a <= 1'b0;
        end else begin
            idx_a <= use_spr ? sprite_pixel : bg_pixel;
            src_a <= use_spr;
        end
    end

    assign lookup = src_a ? spr_pal[idx_a] : bg_pal[idx_a];

    // de_d[DLY-2] is the vde of the pixel now leaving stage A
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {red, green, blue} <= 12'h000;
        end else begin
            {red, green, blue} <= de_d[DLY-2] ? lookup : 12'h000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                bg_pal[i]  <= 12'h000;
                spr_pal[i] <= 12'h000;
            end
        end else if (commit) begin
            if (w_sel) spr_pal[w_addr] <= w_data;
            else       bg_pal[w_addr]  <= w_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_sel  <= 1'b0;
            buf_addr <= 4'h0;
            buf_data <= 12'h000;
        end else if (state == EMPTY && pal.pal_we) begin
            buf_sel  <= pal.pal_sel;
            buf_addr <= pal.pal_addr;
            buf_data <= pal.pal_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (1'b1)
            (state == EMPTY)   && pal.pal_we && vde_in: state_nx = PENDING;
            (state == PENDING) && !vde_in:              state_nx = EMPTY;
            default: ;
        endcase
    end

    // An EMPTY-state request seen during blanking bypasses the buffer
    always_comb begin
        pal.pal_ready = 1'b0;
        commit        = 1'b0;
        w_sel         = buf_sel;
        w_addr        = buf_addr;
        w_data        = buf_data;
        unique case (state)
            EMPTY: begin
                pal.pal_ready = 1'b1;
                commit        = pal.pal_we && !vde_in;
                w_sel         = pal.pal_sel;
                w_addr        = pal.pal_addr;
                w_data        = pal.pal_data;
            end
            PENDING: begin
                commit = !vde_in;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_q        <= 1'b0;
            frame_count <= '0;
        end else begin
            vs_q <= vsync_in;
            if (vsync_in && !vs_q) frame_count <= frame_count + FRAME_W'(1);
        end
    end
endmodule

// File: tb/tb_pixel_compositor.sv
// Directed scenario bench for pixel_compositor: latency, index merge,
// deferred palette writes, blanking, frame counter wrap and async reset.
`timescale 1ns/1ps
module tb_pixel_compositor;
    logic       clk;
    logic       reset;
    logic       hsync_in, vsync_in, vde_in;
    logic [3:0] bg_pixel, sprite_pixel;
    logic       sprite_valid;
    logic [3:0] red, green, blue;
    logic       hsync_out, vsync_out, vde_out;
    logic [7:0] frame_count;
    int         total;
    int         bad;

    pixel_compositor_if pal_bus ();

    pixel_compositor dut (
        .clk          (clk),
        .reset        (reset),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .vde_in       (vde_in),
        .bg_pixel     (bg_pixel),
        .sprite_pixel (sprite_pixel),
        .sprite_valid (sprite_valid),
        .pal          (pal_bus.slave),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .vde_out      (vde_out),
        .frame_count  (frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pal_write(input logic sel, input logic [3:0] addr,
                             input logic [11:0] data);
        pal_bus.pal_we   = 1'b1;
        pal_bus.pal_sel  = sel;
        pal_bus.pal_addr = addr;
        pal_bus.pal_data = data;
        step();
        pal_bus.pal_we = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        hsync_in         = 1'b0;
        vsync_in         = 1'b0;
        vde_in           = 1'b0;
        bg_pixel         = 4'h0;
        sprite_pixel     = 4'h0;
        sprite_valid     = 1'b0;
        pal_bus.pal_we   = 1'b0;
        pal_bus.pal_sel  = 1'b0;
        pal_bus.pal_addr = 4'h0;
        pal_bus.pal_data = 12'h000;
        #23;
        total++;
        if ({red, green, blue} !== 12'h000) begin
            bad++;
            $display("FAIL reset_rgb got=%h want=000", {red, green, blue});
        end
        total++;
        if ({hsync_out, vsync_out, vde_out} !== 3'b000) begin
            bad++;
            $display("FAIL reset_sync got=%b want=000", {hsync_out, vsync_out, vde_out});
        end
        total++;
        if (frame_count !== 8'd0) begin
            bad++;
            $display("FAIL reset_frame got=%0d want=0", frame_count);
        end
        total++;
        if (pal_bus.pal_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b want=1", pal_bus.pal_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        vde_in   = 1'b1;
        hsync_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 1) begin
                vde_in   = 1'b0;
                hsync_in = 1'b0;
            end
            total++;
            if ({hsync_out, vde_out} !== ((i == 3) ? 2'b11 : 2'b00)) begin
                bad++;
                $display("FAIL pulse_delay cycle=%0d got=%b want=%b", i,
                         {hsync_out, vde_out}, (i == 3) ? 2'b11 : 2'b00);
            end
        end
    endtask

    task automatic test_merge();
        pal_write(1'b0, 4'h5, 12'hF00);
        pal_write(1'b1, 4'h5, 12'h0F0);
        vde_in       = 1'b1;
        bg_pixel     = 4'h5;
        sprite_pixel = 4'h5;
        sprite_valid = 1'b1;
        repeat (4) step();
        total++;
        if ({red, green, blue} !== 12'h0F0) begin
            bad++;
            $display("FAIL merge_sprite got=%h want=0F0", {red, green, blue});
        end
        sprite_pixel = 4'h0;
        repeat (4) step();
        total++;
        if ({red, green, blue} !== 12'hF00) begin
            bad++;
            $display("FAIL merge_transparent got=%h want=F00", {red, green, blue});
        end
        sprite_pixel = 4'h5;
        sprite_valid = 1'b0;
        repeat (4) step();
        total++;
        if ({red, green, blue} !== 12'hF00) begin
            bad++;
            $display("FAIL merge_invalid got=%h want=F00", {red, green, blue});
        end
        sprite_pixel = 4'hF;
        sprite_valid = 1'b1;
        repeat (4) step();
        total++;
        if ({red, green, blue} !== 12'h000) begin
            bad++;
            $display("FAIL merge_spr15 got=%h want=000", {red, green, blue});
        end
        sprite_valid = 1'b0;
        vde_in       = 1'b0;
        step();
    endtask

    task automatic test_pending();
        vde_in       = 1'b1;
        bg_pixel     = 4'h2;
        sprite_valid = 1'b0;
        repeat (4) step();
        total++;
        if (pal_bus.pal_ready !== 1'b1) begin
            bad++;
            $display("FAIL pend_ready_pre got=%b want=1", pal_bus.pal_ready);
        end
        pal_bus.pal_we   = 1'b1;
        pal_bus.pal_sel  = 1'b0;
        pal_bus.pal_addr = 4'h2;
        pal_bus.pal_data = 12'hABC;
        step();
        pal_bus.pal_we = 1'b0;
        total++;
        if (pal_bus.pal_ready !== 1'b0) begin
            bad++;
            $display("FAIL pend_ready_busy got=%b want=0", pal_bus.pal_ready);
        end
        repeat (3) step();
        total++;
        if ({red, green, blue} !== 12'h000) begin
            bad++;
            $display("FAIL pend_old_value got=%h want=000", {red, green, blue});
        end
        pal_bus.pal_we   = 1'b1;
        pal_bus.pal_data = 12'h123;
        step();
        pal_bus.pal_we = 1'b0;
        total++;
        if (pal_bus.pal_ready !== 1'b0) begin
            bad++;
            $display("FAIL pend_ignored_ready got=%b want=0", pal_bus.pal_ready);
        end
        step();
        vde_in = 1'b0;
        step();
        total++;
        if (pal_bus.pal_ready !== 1'b1) begin
            bad++;
            $display("FAIL pend_commit_ready got=%b want=1", pal_bus.pal_ready);
        end
        step();
        vde_in = 1'b1;
        repeat (4) step();
        total++;
        if ({red, green, blue} !== 12'hABC) begin
            bad++;
            $display("FAIL pend_new_value got=%h want=ABC", {red, green, blue});
        end
    endtask

    task automatic test_blank_output();
        vde_in   = 1'b0;
        bg_pixel = 4'h2;
        repeat (4) step();
        total++;
        if ({vde_out, red, green, blue} !== 13'h0000) begin
            bad++;
            $display("FAIL blank_rgb got=%b/%h want=0/000", vde_out, {red, green, blue});
        end
    endtask

    task automatic test_frame_wrap();
        int exp_fc;
        exp_fc = 0;
        total++;
        if (frame_count !== 8'(exp_fc)) begin
            bad++;
            $display("FAIL frame_start got=%0d want=%0d", frame_count, exp_fc);
        end
        for (int i = 0; i < 255; i++) begin
            vsync_in = 1'b1;
            step();
            vsync_in = 1'b0;
            step();
            exp_fc = (exp_fc + 1) % 256;
        end
        total++;
        if (frame_count !== 8'(exp_fc)) begin
            bad++;
            $display("FAIL frame_max got=%0d want=%0d", frame_count, exp_fc);
        end
        vsync_in = 1'b1;
        repeat (3) step();
        exp_fc = (exp_fc + 1) % 256;
        total++;
        if (frame_count !== 8'(exp_fc)) begin
            bad++;
            $display("FAIL frame_wrap got=%0d want=%0d", frame_count, exp_fc);
        end
        vsync_in = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        vde_in       = 1'b1;
        hsync_in     = 1'b1;
        bg_pixel     = 4'h5;
        sprite_valid = 1'b0;
        vsync_in     = 1'b1;
        step();
        vsync_in = 1'b0;
        repeat (4) step();
        total++;
        if ({hsync_out, frame_count, red, green, blue} !== {1'b1, 8'd1, 12'hF00}) begin
            bad++;
            $display("FAIL mid_pre got=%b/%0d/%h want=1/1/F00", hsync_out, frame_count,
                     {red, green, blue});
        end
        pal_bus.pal_we   = 1'b1;
        pal_bus.pal_sel  = 1'b0;
        pal_bus.pal_addr = 4'h5;
        pal_bus.pal_data = 12'h00F;
        step();
        pal_bus.pal_we = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({hsync_out, vsync_out, vde_out, frame_count, red, green, blue} !== 23'd0) begin
            bad++;
            $display("FAIL mid_reset got=%b%b%b/%0d/%h want=000/0/000", hsync_out, vsync_out,
                     vde_out, frame_count, {red, green, blue});
        end
        total++;
        if (pal_bus.pal_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_ready got=%b want=1", pal_bus.pal_ready);
        end
        @(negedge clk);
        reset    = 1'b0;
        hsync_in = 1'b0;
        vde_in   = 1'b0;
        repeat (3) step();
        vde_in = 1'b1;
        repeat (4) step();
        total++;
        if ({red, green, blue} !== 12'h000) begin
            bad++;
            $display("FAIL mid_dropped got=%h want=000", {red, green, blue});
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_merge();
        test_pending();
        test_blank_output();
        test_frame_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
